registers: RTL and testbench
============================

REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each register and of every data port.
REQ-002 Parameter ADDR_WIDTH, default 4, register-address width; register count = 2**ADDR_WIDTH (16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 WriteEnable  input  1  global write enable shared by both write ports.
REQ-007 WriteReg1  input  ADDR_WIDTH  write port 1 address.
REQ-008 WriteData1  input  DATA_WIDTH  write port 1 data.
REQ-009 WriteReg2  input  ADDR_WIDTH  write port 2 address.
REQ-010 WriteData2  input  DATA_WIDTH  write port 2 data.
REQ-011 ReadReg1  input  ADDR_WIDTH  read port 1 address.
REQ-012 ReadReg2  input  ADDR_WIDTH  read port 2 address.
REQ-013 RegOut1  output  DATA_WIDTH  read port 1 data.
REQ-014 RegOut2  output  DATA_WIDTH  read port 2 data.

Function
REQ-015 Storage SHALL be 16 independent DATA_WIDTH-bit registers, all writable (no hardwired register).
REQ-016 Reads SHALL be combinational: RegOutN = reg[ReadRegN] in the same cycle, zero clock latency.
REQ-017 Both read ports SHALL operate independently; equal addresses return identical data.
REQ-018 On rising clk with rst=0 and WriteEnable=1, reg[WriteReg1] <= WriteData1 and reg[WriteReg2] <= WriteData2.
REQ-019 With WriteEnable=0, no register SHALL change regardless of write addresses/data.
REQ-020 Simultaneous writes to the same address: port 2 SHALL win (reg gets WriteData2).
REQ-021 X/unknown write address or data with WriteEnable=0 SHALL NOT affect state.
REQ-022 Written value SHALL be visible on a read port from the edge that writes it (next cycle), unless bypass per REQ-027.

Reset
REQ-023 On rising clk with rst=1, all 16 registers SHALL be cleared to 0.
REQ-024 Reset SHALL have priority over writes in the same cycle; writes that cycle are discarded.
REQ-025 After reset, RegOut1/RegOut2 SHALL read 0 for every address until written.
REQ-026 Reset asserted mid-operation SHALL clear all prior contents in one cycle; no asynchronous effect between edges.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN: when defined, if WriteEnable=1 and rst=0 and ReadRegN matches a write address, RegOutN SHALL return the pending write data combinationally (port 2 data on double match); when undefined, RegOutN SHALL always reflect stored contents only.

Verification
REQ-028 Assert rst=1 one edge, release, sweep ReadReg1/ReadReg2 over 0..15 -> RegOut1=RegOut2=0x0000 at every address.
REQ-029 WriteEnable=1, WriteReg2=13, WriteData2=0xAAAA, WriteReg1=2, WriteData1=0x1234, one edge -> read reg13=0xAAAA, reg2=0x1234, all others 0.
REQ-030 WriteEnable=0, WriteReg1=15, WriteData1=0xFFFF, several edges -> reg15 stays 0x0000.
REQ-031 WriteEnable=1, WriteReg1=WriteReg2=7, WriteData1=0x1111, WriteData2=0x2222 -> reg7=0x2222.
REQ-032 reg13=0xAAAA, then rst=1 with WriteEnable=1 to reg13=0x5555 on same edge -> reg13=0x0000.
REQ-033 Bypass: WriteReg1=4, WriteData1=0xBEEF, WriteEnable=1, ReadReg1=4 before edge -> RegOut1=0xBEEF with REGFILE_BYPASS_EN defined, old value (0x0000) without.

Source files
------------

// File: rtl/registers.sv
// ---------------------------------------------------------------------------
// registers -- 2-write / 2-read register file, 2**ADDR_WIDTH x DATA_WIDTH.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset, clears every register
//   WriteEnable  global write enable shared by both write ports
//   WriteReg1/2  write port addresses
//   WriteData1/2 write port data (port 2 wins on equal addresses)
//   ReadReg1/2   read port addresses
//   RegOut1/2    combinational read data
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read that matches a pending write
//                      address returns the write data in the same cycle
//                      (port 2 data on a double match). Default: stored
//                      contents only.
// ---------------------------------------------------------------------------

// One storage word. Reset dominates both write strobes; port 2 dominates
// port 1 so a same-address double write keeps WriteData2.
module registers_cell #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr1_i,
  input  logic                  wr2_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic [DATA_WIDTH-1:0] wdata2_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (wr2_i)      word_d = wdata2_i;
    else if (wr1_i) word_d = wdata1_i;
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q_o = word_q;
endmodule

module registers #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteReg1,
  input  logic [DATA_WIDTH-1:0] WriteData1,
  input  logic [ADDR_WIDTH-1:0] WriteReg2,
  input  logic [DATA_WIDTH-1:0] WriteData2,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] RegOut1,
  output logic [DATA_WIDTH-1:0] RegOut2
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wreq_t;

  wreq_t wreq1, wreq2;
  assign wreq1 = '{addr: WriteReg1, data: WriteData1};
  assign wreq2 = '{addr: WriteReg2, data: WriteData2};

  logic [NUM_REGS-1:0]                 wr1, wr2;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Bitwise AND with WriteEnable: when it is 0 the strobes are 0 even if
  // the address compares are unknown, so X addresses cannot disturb state.
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      assign wr1[g] = WriteEnable & (wreq1.addr == ADDR_WIDTH'(g));
      assign wr2[g] = WriteEnable & (wreq2.addr == ADDR_WIDTH'(g));

      registers_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .wr1_i    (wr1[g]),
        .wr2_i    (wr2[g]),
        .wdata1_i (wreq1.data),
        .wdata2_i (wreq2.data),
        .q_o      (regs[g])
      );
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rd1, rd2;
  assign rd1 = regs[ReadReg1];
  assign rd2 = regs[ReadReg2];

`ifdef REGFILE_BYPASS_EN
  // Forward pending write data; check port 2 first so it wins a double match.
  logic byp_en;
  assign byp_en = WriteEnable & ~rst;

  always_comb begin
    RegOut1 = rd1;
    if (byp_en && ReadReg1 == wreq2.addr)      RegOut1 = wreq2.data;
    else if (byp_en && ReadReg1 == wreq1.addr) RegOut1 = wreq1.data;
  end

  always_comb begin
    RegOut2 = rd2;
    if (byp_en && ReadReg2 == wreq2.addr)      RegOut2 = wreq2.data;
    else if (byp_en && ReadReg2 == wreq1.addr) RegOut2 = wreq1.data;
  end
`else
  assign RegOut1 = rd1;
  assign RegOut2 = rd2;
`endif

endmodule

// File: tb/tb_registers.sv
module tb_registers;
  logic        clk = 1'b0;
  logic        rst;
  logic        WriteEnable;
  logic [3:0]  WriteReg1, WriteReg2, ReadReg1, ReadReg2;
  logic [15:0] WriteData1, WriteData2;
  logic [15:0] RegOut1, RegOut2;

  always #5 clk = ~clk;

  registers #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .WriteEnable(WriteEnable),
    .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .WriteReg2(WriteReg2), .WriteData2(WriteData2),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .RegOut1(RegOut1), .RegOut2(RegOut2)
  );

  typedef struct {
    int          tag;
    logic [3:0]  a1, a2;
    logic [15:0] e1, e2;
  } exp_t;

  exp_t        sb[$];
  logic        rd_vld = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          tag    = 0;
  logic [15:0] mdl [16];

  // Monitor: one expected entry per strobed read cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard underflow: read strobed with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        if (RegOut1 === e.e1) n_pass++;
        else $display("FAIL rd#%0d port1 addr=%0d got=%h exp=%h", e.tag, e.a1, RegOut1, e.e1);
        n_chk++;
        if (RegOut2 === e.e2) n_pass++;
        else $display("FAIL rd#%0d port2 addr=%0d got=%h exp=%h", e.tag, e.a2, RegOut2, e.e2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe one read cycle; the write inputs keep whatever the caller left.
  task automatic rd(input logic [3:0] a1, input logic [3:0] a2,
                    input logic [15:0] e1, input logic [15:0] e2);
    exp_t e;
    ReadReg1 = a1;
    ReadReg2 = a2;
    e.tag = tag; e.a1 = a1; e.a2 = a2; e.e1 = e1; e.e2 = e2;
    tag++;
    sb.push_back(e);
    rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
  endtask

  task automatic rd_mdl(input logic [3:0] a1, input logic [3:0] a2);
    rd(a1, a2, mdl[a1], mdl[a2]);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) rd_mdl(4'(i), 4'(15 - i));
  endtask

  task automatic wr(input logic [3:0] a1, input logic [15:0] d1,
                    input logic [3:0] a2, input logic [15:0] d2);
    WriteEnable = 1'b1;
    WriteReg1 = a1; WriteData1 = d1;
    WriteReg2 = a2; WriteData2 = d2;
    step();
    WriteEnable = 1'b0;
    mdl[a1] = d1;
    mdl[a2] = d2;   // port 2 wins an equal address
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    rst = 1'b1; WriteEnable = 1'b0;
    WriteReg1 = 4'd0; WriteReg2 = 4'd0; WriteData1 = '0; WriteData2 = '0;
    ReadReg1 = 4'd0; ReadReg2 = 4'd0;
    step();
    rst = 1'b0;

    // Reset state: every address reads zero on both ports.
    sweep();

    // Dual write to distinct addresses.
    wr(4'd2, 16'h1234, 4'd13, 16'hAAAA);
    rd(4'd13, 4'd2, 16'hAAAA, 16'h1234);
    sweep();

    // Write enable low: nothing changes, including with unknown inputs.
    WriteReg1 = 4'd15; WriteData1 = 16'hFFFF;
    WriteReg2 = 4'd3;  WriteData2 = 16'h3333;
    step(); step(); step();
    rd(4'd15, 4'd3, 16'h0000, 16'h0000);
    WriteReg1 = 'x; WriteData1 = 'x; WriteReg2 = 'x; WriteData2 = 'x;
    step(); step();
    rd(4'd15, 4'd13, 16'h0000, 16'hAAAA);
    rd(4'd2, 4'd2, 16'h1234, 16'h1234);   // equal read addresses

    // Same-address write: port 2 wins.
    wr(4'd7, 16'h1111, 4'd7, 16'h2222);
    rd(4'd7, 4'd7, 16'h2222, 16'h2222);

    // Reset beats a write on the same edge and clears everything.
    rst = 1'b1; WriteEnable = 1'b1;
    WriteReg1 = 4'd13; WriteData1 = 16'h5555;
    WriteReg2 = 4'd13; WriteData2 = 16'h5555;
    step();
    rst = 1'b0; WriteEnable = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    rd(4'd13, 4'd7, 16'h0000, 16'h0000);
    rd(4'd2, 4'd5, 16'h0000, 16'h0000);

    // Read of a pending write address before the writing edge.
    WriteEnable = 1'b1;
    WriteReg1 = 4'd4; WriteData1 = 16'hBEEF;
    WriteReg2 = 4'd9; WriteData2 = 16'h0909;
`ifdef REGFILE_BYPASS_EN
    rd(4'd4, 4'd9, 16'hBEEF, 16'h0909);
`else
    rd(4'd4, 4'd9, 16'h0000, 16'h0000);
`endif
    WriteEnable = 1'b0;
    mdl[4] = 16'hBEEF; mdl[9] = 16'h0909;
    rd(4'd4, 4'd9, 16'hBEEF, 16'h0909);

    // Boundary addresses and full sweep.
    wr(4'd0, 16'h0001, 4'd15, 16'h8000);
    rd(4'd0, 4'd15, 16'h0001, 16'h8000);
    sweep();

    // Drain: every pushed entry must have been consumed.
    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
